// File: rtl/reorder_buffer.sv
// In-order retirement buffer: circular queue of issued instructions, result capture
// from the writeback bus, program-order commit and combinational operand lookups.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic                     full,
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_val,
  input  logic                     wb_taken,
  output logic [4:0]               set_reg_id,
  output logic [31:0]              set_val,
  output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  output logic                     store_commit,
  output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
  output logic                     rob_clear,
  output logic [31:0]              clear_pc,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  output logic                     rob_value1_ready,
  output logic                     rob_value2_ready,
  output logic [31:0]              rob_value1,
  output logic [31:0]              rob_value2
);
  localparam int DEPTH = 2 ** ROB_WIDTH_BIT;
  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_BRANCH = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;
  localparam logic [ROB_WIDTH_BIT:0]   CNT_ONE  = (ROB_WIDTH_BIT+1)'(1);
  localparam logic [ROB_WIDTH_BIT:0]   CNT_FULL = (ROB_WIDTH_BIT+1)'(DEPTH);
  localparam logic [ROB_WIDTH_BIT-1:0] PTR_ONE  = ROB_WIDTH_BIT'(1);

  logic [ROB_WIDTH_BIT-1:0] head_q, tail_q;
  logic [ROB_WIDTH_BIT:0]   count_q, count_d;
  logic                     full_q;
  logic [DEPTH-1:0]         busy_q, ready_q;

  logic [1:0]  type_q  [DEPTH];
  logic [4:0]  rd_q    [DEPTH];
  logic [31:0] val_q   [DEPTH];
  logic [31:0] alt_q   [DEPTH];
  logic        pred_q  [DEPTH];
  logic        taken_q [DEPTH];

  logic [4:0]               set_reg_id_q;
  logic [31:0]              set_val_q, clear_pc_q;
  logic [ROB_WIDTH_BIT-1:0] set_rob_q, store_rob_q;
  logic                     store_commit_q, rob_clear_q;

  logic issue_acc, wb_acc, commit;

  // Nothing is accepted during the flush cycle; the queue is emptied at its end.
  assign issue_acc = issue_valid && !full_q && !rob_clear_q;
  assign wb_acc    = wb_valid && busy_q[wb_rob_id] && !rob_clear_q;
  assign commit    = (count_q != '0) && busy_q[head_q] && ready_q[head_q] && !rob_clear_q;

  always_comb begin
    count_d = count_q;
    if (issue_acc && !commit)
      count_d = count_q + CNT_ONE;
    else if (!issue_acc && commit)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      busy_q         <= '0;
      ready_q        <= '0;
      set_reg_id_q   <= '0;
      set_val_q      <= '0;
      set_rob_q      <= '0;
      store_commit_q <= 1'b0;
      store_rob_q    <= '0;
      rob_clear_q    <= 1'b0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      set_reg_id_q   <= '0;
      store_commit_q <= 1'b0;
      rob_clear_q    <= 1'b0;
      if (rob_clear_q) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        full_q  <= 1'b0;
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (wb_acc)
          ready_q[wb_rob_id] <= 1'b1;
        if (issue_acc) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + PTR_ONE;
        end
        if (commit) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + PTR_ONE;
          case (type_q[head_q])
            T_BRANCH: begin
              if (taken_q[head_q] != pred_q[head_q]) begin
                rob_clear_q <= 1'b1;
                clear_pc_q  <= alt_q[head_q];
              end
            end
            T_STORE: begin
              store_commit_q <= 1'b1;
              store_rob_q    <= head_q;
            end
            default: begin
              set_reg_id_q <= rd_q[head_q];
              set_val_q    <= val_q[head_q];
              set_rob_q    <= head_q;
            end
          endcase
        end
        count_q <= count_d;
        full_q  <= (count_d == CNT_FULL);
      end
    end
  end

  // Type 3 is folded into a REG entry with no destination at allocation time.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (issue_acc) begin
        type_q[tail_q] <= (issue_type == 2'd3) ? T_REG : issue_type;
        rd_q[tail_q]   <= (issue_type == 2'd3) ? 5'd0 : issue_rd;
        pred_q[tail_q] <= issue_pred_taken;
        alt_q[tail_q]  <= issue_alt_pc;
      end
      if (wb_acc) begin
        val_q[wb_rob_id]   <= wb_val;
        taken_q[wb_rob_id] <= wb_taken;
      end
    end
  end

  assign rob_value1_ready = (busy_q[get_rob_id1] && ready_q[get_rob_id1]) ||
                            (wb_valid && wb_rob_id == get_rob_id1);
  assign rob_value2_ready = (busy_q[get_rob_id2] && ready_q[get_rob_id2]) ||
                            (wb_valid && wb_rob_id == get_rob_id2);
  assign rob_value1 = (wb_valid && wb_rob_id == get_rob_id1) ? wb_val : val_q[get_rob_id1];
  assign rob_value2 = (wb_valid && wb_rob_id == get_rob_id2) ? wb_val : val_q[get_rob_id2];

  assign issue_rob_id      = tail_q;
  assign full              = full_q;
  assign set_reg_id        = set_reg_id_q;
  assign set_val           = set_val_q;
  assign set_reg_on_rob_id = set_rob_q;
  assign store_commit      = store_commit_q;
  assign store_rob_id      = store_rob_q;
  assign rob_clear         = rob_clear_q;
  assign clear_pc          = clear_pc_q;
endmodule
